// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM wishbone arbiter.
// Arbiter state encoding doubles as the gnt encoding.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } arb_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;

    // One master's request bundle, in slave-port order.
    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [23:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [2:0]  cti;
    } wb_req_t;

endpackage

// File: rtl/sdram_arb_starve.sv
// Starvation counter for the SDRAM arbiter: counts m0 wins while m1
// waits and flags when m1 is owed the next grant.
module sdram_arb_starve #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_max_o
);

    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    // Saturating count; a grant to m1 always wins over an increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 3'd0;
        end else if (inc_i && (cnt_q != 3'd7)) begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    // Counter register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == 3'(STARVE_MAX));

endmodule

// File: rtl/sdram_arb.sv
// Two-master wishbone arbiter in front of the SDRAM controller.
// Optional m1 anti-starvation under macro SDRAM_ARB_STARVE_EN.
module sdram_arb
    import sdram_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        wb_clk,
    input  logic        wb_rst_n,

    input  logic        m0_cyc,
    input  logic        m0_stb,
    input  logic        m0_we,
    input  logic [23:0] m0_adr,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel,
    input  logic [2:0]  m0_cti,
    output logic        m0_ack,

    input  logic        m1_cyc,
    input  logic        m1_stb,
    input  logic        m1_we,
    input  logic [23:0] m1_adr,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel,
    input  logic [2:0]  m1_cti,
    output logic        m1_ack,

    output logic [31:0] m_dat_o,

    output logic        s_cyc,
    output logic        s_stb,
    output logic        s_we,
    output logic [23:0] s_adr,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel,
    output logic [2:0]  s_cti,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack,

    output logic [1:0]  gnt
);

    arb_state_e state_q;
    arb_state_e state_d;

    // Low for the first edge after reset so no grant lands on it.
    logic arb_en_q;
    logic arb_en_d;

    logic    m0_req;
    logic    m1_req;
    logic    starve;
    wb_req_t m0_bus;
    wb_req_t m1_bus;
    wb_req_t s_bus;

    assign m0_req = m0_cyc & m0_stb;
    assign m1_req = m1_cyc & m1_stb;

    assign m0_bus = {m0_cyc, m0_stb, m0_we, m0_adr,
                     m0_dat_i, m0_sel, m0_cti};
    assign m1_bus = {m1_cyc, m1_stb, m1_we, m1_adr,
                     m1_dat_i, m1_sel, m1_cti};

`ifdef SDRAM_ARB_STARVE_EN
    logic starve_inc;
    logic starve_clr;
    logic at_max;

    assign starve_inc = (state_q == IDLE) & (state_d == G0) & m1_req;
    assign starve_clr = (state_q == IDLE) & (state_d == G1);

    sdram_arb_starve #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk      (wb_clk),
        .rst_n    (wb_rst_n),
        .inc_i    (starve_inc),
        .clr_i    (starve_clr),
        .at_max_o (at_max)
    );

    assign starve = at_max & m1_req;
`else
    // Strict priority: STARVE_MAX only matters with the counter built in.
    assign starve = 1'b0 && (STARVE_MAX > 7);
`endif

    // Next-state: arbitrate from IDLE, hold while owner keeps cyc.
    always_comb begin
        state_d  = state_q;
        arb_en_d = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (arb_en_q) begin
                    if (m0_req && !starve) begin
                        state_d = G0;
                    end else if (m1_req) begin
                        state_d = G1;
                    end
                end
            end
            G0: begin
                if (!m0_cyc) begin
                    state_d = IDLE;
                end
            end
            G1: begin
                if (!m1_cyc) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset drops any transaction in flight.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q  <= IDLE;
            arb_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            arb_en_q <= arb_en_d;
        end
    end

    // Steer the owner onto the slave port and route its ack back.
    always_comb begin
        s_bus     = '0;
        s_bus.cti = CTI_CLASSIC;
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        unique case (state_q)
            G0: begin
                s_bus  = m0_bus;
                m0_ack = s_ack;
            end
            G1: begin
                s_bus  = m1_bus;
                m1_ack = s_ack;
            end
            default: begin
            end
        endcase
    end

    assign s_cyc   = s_bus.cyc;
    assign s_stb   = s_bus.stb;
    assign s_we    = s_bus.we;
    assign s_adr   = s_bus.adr;
    assign s_dat_o = s_bus.dat;
    assign s_sel   = s_bus.sel;
    assign s_cti   = s_bus.cti;

    assign m_dat_o = s_dat_i;
    assign gnt     = state_q;

endmodule

// File: tb/tb_sdram_arb.sv
// Self-checking bench for sdram_arb: directed scenarios plus
// randomized traffic against an ownership-level reference model.
module tb_sdram_arb;
    import sdram_arb_pkg::*;

    localparam int STARVE_MAX = 4;

    logic        wb_clk = 1'b0;
    logic        wb_rst_n = 1'b0;
    logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
    logic [23:0] m0_adr = '0;
    logic [31:0] m0_dat_i = '0;
    logic [3:0]  m0_sel = '0;
    logic [2:0]  m0_cti = '0;
    logic        m0_ack;
    logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [23:0] m1_adr = '0;
    logic [31:0] m1_dat_i = '0;
    logic [3:0]  m1_sel = '0;
    logic [2:0]  m1_cti = '0;
    logic        m1_ack;
    logic [31:0] m_dat_o;
    logic        s_cyc, s_stb, s_we;
    logic [23:0] s_adr;
    logic [31:0] s_dat_o;
    logic [3:0]  s_sel;
    logic [2:0]  s_cti;
    logic [31:0] s_dat_i = '0;
    logic        s_ack = 1'b0;
    logic [1:0]  gnt;

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the slave (0 none, 1 m0, 2 m1),
    // how many m0 wins m1 has sat through, and whether the first
    // post-reset edge has passed.
    int owner;
    int waits;
    bit armed;

    sdram_arb #(.STARVE_MAX(STARVE_MAX)) dut (
        .wb_clk   (wb_clk),   .wb_rst_n (wb_rst_n),
        .m0_cyc   (m0_cyc),   .m0_stb   (m0_stb),
        .m0_we    (m0_we),    .m0_adr   (m0_adr),
        .m0_dat_i (m0_dat_i), .m0_sel   (m0_sel),
        .m0_cti   (m0_cti),   .m0_ack   (m0_ack),
        .m1_cyc   (m1_cyc),   .m1_stb   (m1_stb),
        .m1_we    (m1_we),    .m1_adr   (m1_adr),
        .m1_dat_i (m1_dat_i), .m1_sel   (m1_sel),
        .m1_cti   (m1_cti),   .m1_ack   (m1_ack),
        .m_dat_o  (m_dat_o),
        .s_cyc    (s_cyc),    .s_stb    (s_stb),
        .s_we     (s_we),     .s_adr    (s_adr),
        .s_dat_o  (s_dat_o),  .s_sel    (s_sel),
        .s_cti    (s_cti),    .s_dat_i  (s_dat_i),
        .s_ack    (s_ack),    .gnt      (gnt)
    );

    always #5 wb_clk = ~wb_clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic void model_reset();
        owner = 0;
        waits = 0;
        armed = 1'b0;
    endfunction

    function automatic void model_step();
        bit r0;
        bit r1;
        r0 = m0_cyc && m0_stb;
        r1 = m1_cyc && m1_stb;
        if (!armed) begin
            armed = 1'b1;
        end else if (owner == 1) begin
            if (!m0_cyc) owner = 0;
        end else if (owner == 2) begin
            if (!m1_cyc) owner = 0;
        end else begin
`ifdef SDRAM_ARB_STARVE_EN
            if (r1 && waits == STARVE_MAX) begin
                owner = 2;
                waits = 0;
            end else
`endif
            if (r0) begin
                owner = 1;
                if (r1 && waits < 7) waits++;
            end else if (r1) begin
                owner = 2;
                waits = 0;
            end
        end
    endfunction

    function automatic wb_req_t model_bus();
        wb_req_t b;
        b = '0;
        if (owner == 1)
            b = {m0_cyc, m0_stb, m0_we, m0_adr,
                 m0_dat_i, m0_sel, m0_cti};
        else if (owner == 2)
            b = {m1_cyc, m1_stb, m1_we, m1_adr,
                 m1_dat_i, m1_sel, m1_cti};
        return b;
    endfunction

    task automatic tick();
        @(posedge wb_clk);
        if (wb_rst_n) model_step();
        #1;
    endtask

    task automatic drop_all();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_cti = CTI_CLASSIC;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_cti = CTI_CLASSIC;
        s_ack = 0;
    endtask

    task automatic test_reset();
        wb_rst_n = 1'b0;
        model_reset();
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        s_ack = 1;
        #1;
        checks++; if (gnt !== 2'b00) begin errors++;
            $display("FAIL rst_gnt got=%b exp=00", gnt); end
        checks++; if ({s_cyc, s_stb} !== 2'b00) begin errors++;
            $display("FAIL rst_scyc got=%b%b exp=00", s_cyc, s_stb); end
        checks++; if ({m0_ack, m1_ack} !== 2'b00) begin errors++;
            $display("FAIL rst_ack got=%b%b exp=00", m0_ack, m1_ack); end
        tick();
        checks++; if (gnt !== 2'b00) begin errors++;
            $display("FAIL rst_hold got=%b exp=00", gnt); end
        wb_rst_n = 1'b1;
        s_ack = 0;
        tick();
        checks++; if (gnt !== 2'b00) begin errors++;
            $display("FAIL rst_first_edge got=%b exp=00", gnt); end
        tick();
        checks++; if (gnt !== 2'b01) begin errors++;
            $display("FAIL rst_second_edge got=%b exp=01", gnt); end
        drop_all();
        tick();
        checks++; if (gnt !== 2'b00) begin errors++;
            $display("FAIL rst_release got=%b exp=00", gnt); end
    endtask

    task automatic test_m1_read();
        m1_cyc = 1; m1_stb = 1; m1_we = 0;
        m1_adr = 24'h001000; m1_sel = 4'hF;
        #1;
        checks++; if (gnt !== 2'b00) begin errors++;
            $display("FAIL rd_pre got=%b exp=00", gnt); end
        tick();
        checks++; if (gnt !== 2'b10) begin errors++;
            $display("FAIL rd_gnt got=%b exp=10", gnt); end
        checks++; if (s_adr !== 24'h001000 || s_cyc !== 1'b1) begin
            errors++;
            $display("FAIL rd_sadr got=%h/%b exp=001000/1", s_adr, s_cyc); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (m1_ack !== 1'b0) begin errors++;
                $display("FAIL rd_noack got=%b exp=0", m1_ack); end
        end
        s_ack = 1; s_dat_i = 32'hDEADBEEF;
        #1;
        checks++; if ({m0_ack, m1_ack} !== 2'b01) begin errors++;
            $display("FAIL rd_ack got=%b%b exp=01", m0_ack, m1_ack); end
        checks++; if (m_dat_o !== 32'hDEADBEEF) begin errors++;
            $display("FAIL rd_data got=%h exp=deadbeef", m_dat_o); end
        tick();
        s_ack = 0; m1_cyc = 0; m1_stb = 0;
        #1;
        checks++; if (m1_ack !== 1'b0 || gnt !== 2'b10) begin errors++;
            $display("FAIL rd_end got=%b/%b exp=0/10", m1_ack, gnt); end
        tick();
        checks++; if (gnt !== 2'b00 || s_cyc !== 1'b0) begin errors++;
            $display("FAIL rd_idle got=%b/%b exp=00/0", gnt, s_cyc); end
    endtask

    task automatic test_simultaneous();
        m0_cyc = 1; m0_stb = 1; m0_adr = 24'hABCDEF;
        m1_cyc = 1; m1_stb = 1; m1_adr = 24'h000123;
        tick();
        checks++; if (gnt !== 2'b01) begin errors++;
            $display("FAIL sim_gnt got=%b exp=01", gnt); end
        checks++; if (s_adr !== 24'hABCDEF) begin errors++;
            $display("FAIL sim_sadr got=%h exp=abcdef", s_adr); end
        s_ack = 1;
        #1;
        checks++; if ({m0_ack, m1_ack} !== 2'b10) begin errors++;
            $display("FAIL sim_ack got=%b%b exp=10", m0_ack, m1_ack); end
        tick();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        tick();
        checks++; if (gnt !== 2'b00 || s_cyc !== 1'b0) begin errors++;
            $display("FAIL sim_gap got=%b/%b exp=00/0", gnt, s_cyc); end
        tick();
        checks++; if (gnt !== 2'b10 || s_adr !== 24'h000123) begin
            errors++;
            $display("FAIL sim_m1 got=%b/%h exp=10/000123", gnt, s_adr); end
        drop_all();
        tick();
    endtask

    task automatic test_burst();
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_cti = CTI_INCR;
        m0_dat_i = 32'h12345678;
        m1_cyc = 1; m1_stb = 1;
        tick();
        checks++; if (gnt !== 2'b01 || s_cti !== CTI_INCR) begin
            errors++;
            $display("FAIL bst_start got=%b/%b exp=01/010", gnt, s_cti); end
        checks++; if (s_we !== 1'b1 || s_dat_o !== 32'h12345678) begin
            errors++;
            $display("FAIL bst_wdat got=%b/%h exp=1/12345678", s_we, s_dat_o);
        end
        s_ack = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({gnt, s_cti, m0_ack, m1_ack} !== {2'b01, CTI_INCR, 2'b10})
            begin
                errors++;
                $display("FAIL bst_ack%0d got=%b/%b/%b%b exp=01/010/10",
                         i, gnt, s_cti, m0_ack, m1_ack);
            end
            tick();
        end
        s_ack = 0; m0_cyc = 0; m0_stb = 0; m0_we = 0;
        #1;
        checks++; if (gnt !== 2'b01 || m1_ack !== 1'b0) begin errors++;
            $display("FAIL bst_hold got=%b/%b exp=01/0", gnt, m1_ack); end
        tick();
        checks++; if (gnt !== 2'b00) begin errors++;
            $display("FAIL bst_gap got=%b exp=00", gnt); end
        tick();
        checks++; if (gnt !== 2'b10) begin errors++;
            $display("FAIL bst_m1 got=%b exp=10", gnt); end
        drop_all();
        tick();
    endtask

    task automatic test_reset_mid();
        m1_cyc = 1; m1_stb = 1;
        tick();
        checks++; if (gnt !== 2'b10) begin errors++;
            $display("FAIL rmid_gnt got=%b exp=10", gnt); end
        s_ack = 1;
        #1;
        checks++; if (m1_ack !== 1'b1) begin errors++;
            $display("FAIL rmid_ack got=%b exp=1", m1_ack); end
        wb_rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({gnt, s_cyc, m0_ack, m1_ack} !== 5'b00000) begin
            errors++;
            $display("FAIL rmid_abort got=%b/%b/%b%b exp=00/0/00",
                     gnt, s_cyc, m0_ack, m1_ack);
        end
        tick();
        wb_rst_n = 1'b1;
        s_ack = 0;
        tick();
        checks++; if (gnt !== 2'b00) begin errors++;
            $display("FAIL rmid_first got=%b exp=00", gnt); end
        tick();
        checks++; if (gnt !== 2'b10) begin errors++;
            $display("FAIL rmid_rearb got=%b exp=10", gnt); end
        drop_all();
        tick();
    endtask

    task automatic test_starve();
        logic [1:0] exp_seq [6];
        wb_rst_n = 1'b0;
        model_reset();
        drop_all();
        tick();
        wb_rst_n = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) exp_seq[i] = 2'b01;
`ifdef SDRAM_ARB_STARVE_EN
        exp_seq[STARVE_MAX] = 2'b10;
`endif
        for (int i = 0; i < 6; i++) begin
            m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
            tick();
            checks++; if (gnt !== exp_seq[i]) begin errors++;
                $display("FAIL stv_seq%0d got=%b exp=%b", i, gnt, exp_seq[i]);
            end
            if (gnt == 2'b10) begin
                m1_cyc = 0; m1_stb = 0;
            end else begin
                m0_cyc = 0; m0_stb = 0;
            end
            tick();
            checks++; if (gnt !== 2'b00) begin errors++;
                $display("FAIL stv_gap%0d got=%b exp=00", i, gnt); end
        end
        drop_all();
        tick();
    endtask

    task automatic test_random();
        wb_req_t got;
        wb_req_t exp;
        logic [1:0] exp_gnt;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(60) == 0) begin
                wb_rst_n = 1'b0;
                model_reset();
            end else begin
                wb_rst_n = 1'b1;
            end
            if ($urandom_range(3) == 0) m0_cyc = ~m0_cyc;
            if ($urandom_range(4) == 0) m1_cyc = ~m1_cyc;
            m0_stb = m0_cyc & ($urandom_range(3) != 0);
            m1_stb = m1_cyc & ($urandom_range(3) != 0);
            m0_we = 1'($urandom); m1_we = 1'($urandom);
            m0_adr = 24'($urandom); m1_adr = 24'($urandom);
            m0_dat_i = $urandom; m1_dat_i = $urandom;
            m0_sel = 4'($urandom); m1_sel = 4'($urandom);
            m0_cti = 3'($urandom); m1_cti = 3'($urandom);
            s_ack = 1'($urandom); s_dat_i = $urandom;
            #1;
            exp = model_bus();
            exp_gnt = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
            got = {s_cyc, s_stb, s_we, s_adr, s_dat_o, s_sel, s_cti};
            checks++; if (gnt !== exp_gnt) begin errors++;
                $display("FAIL rnd_gnt n=%0d got=%b exp=%b", n, gnt, exp_gnt);
            end
            checks++; if (got !== exp) begin errors++;
                $display("FAIL rnd_bus n=%0d got=%h exp=%h", n, got, exp);
            end
            checks++;
            if ({m0_ack, m1_ack} !==
                {s_ack && owner == 1, s_ack && owner == 2}) begin
                errors++;
                $display("FAIL rnd_ack n=%0d got=%b%b own=%0d sack=%b",
                         n, m0_ack, m1_ack, owner, s_ack);
            end
            checks++; if (m_dat_o !== s_dat_i) begin errors++;
                $display("FAIL rnd_rdat n=%0d got=%h exp=%h",
                         n, m_dat_o, s_dat_i);
            end
            tick();
        end
        wb_rst_n = 1'b1;
        drop_all();
        tick();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_m1_read();
        test_simultaneous();
        test_burst();
        test_reset_mid();
        test_starve();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdram_arb.md
SDRAM_ARB -- requirements
Module: sdram_arb

Interface
REQ-001 Parameter STARVE_MAX, default 4: consecutive m0 grants allowed while m1 is waiting (used only with SDRAM_ARB_STARVE_EN).
REQ-002 wb_clk  input  1  chipset clock; all logic is synchronous to its rising edge.
REQ-003 wb_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 m0_cyc, m0_stb, m0_we  input  1 each  master 0 (video/DMA, high priority) wishbone controls.
REQ-005 m0_adr  input  24;  m0_dat_i  input  32;  m0_sel  input  4;  m0_cti  input  3  master 0 address, write data, byte lanes, cycle type.
REQ-006 m0_ack  output  1  master 0 acknowledge.
REQ-007 m1_cyc, m1_stb, m1_we, m1_adr, m1_dat_i, m1_sel, m1_cti, m1_ack: master 1 (CPU), same directions and widths as m0.
REQ-008 m_dat_o  output  32  read data, broadcast to both masters.
REQ-009 s_cyc, s_stb, s_we  output  1 each;  s_adr  output  24;  s_dat_o  output  32;  s_sel  output  4;  s_cti  output  3  controls toward the SDRAM wishbone slave.
REQ-010 s_dat_i  input  32;  s_ack  input  1  slave read data and acknowledge.
REQ-011 gnt  output  2  grant status: 00 none, 01 m0, 10 m1.

Function
REQ-012 States: IDLE, G0 (m0 owns slave), G1 (m1 owns slave); state is held in a register and gnt decodes it directly.
REQ-013 In IDLE, a request is mx_cyc & mx_stb.
REQ-014 IDLE arbitration:
  - m0 request -> G0 on the next edge.
  - else m1 request -> G1 on the next edge.
  - else stay in IDLE.
  - Arbitration latency is one cycle.
REQ-015 Simultaneous m0 and m1 requests in IDLE: m0 wins, unless the starvation rule (REQ-022) applies.
REQ-016 In G0/G1, s_cyc, s_stb, s_we, s_adr, s_dat_o, s_sel and s_cti are combinational copies of the granted master's signals.
REQ-017 In IDLE, s_cyc = s_stb = s_we = 0, and s_adr, s_dat_o, s_sel and s_cti = 0.
REQ-018 Acknowledge routing:
  - m0_ack = s_ack & (state == G0); m1_ack = s_ack & (state == G1).
  - The ungranted master's ack is 0 in every cycle.
REQ-019 m_dat_o = s_dat_i in every state, with no register stage.
REQ-020 Grant is held while the granted master keeps cyc high, across any number of acks, so a cti=010 burst (two acks) completes unbroken.
REQ-021 Release:
  - When the granted master's cyc is sampled low, the state returns to IDLE on that edge.
  - One IDLE cycle always separates two grants, so s_cyc is low for at least one cycle between owners.
REQ-022 With SDRAM_ARB_STARVE_EN defined:
  - A 3-bit saturating counter increments on each IDLE->G0 transition taken while m1 is requesting.
  - The counter clears on IDLE->G1.
  - When the counter equals STARVE_MAX and m1 is requesting in IDLE, the grant goes to G1 even if m0 is requesting.
REQ-023 An s_ack arriving in IDLE is dropped and reaches neither master.

Reset
REQ-024 Asserting wb_rst_n low forces state = IDLE and the starvation counter = 0 immediately, without waiting for a clock edge.
REQ-025 While wb_rst_n is low: gnt = 00, s_cyc = s_stb = 0, m0_ack = m1_ack = 0.
REQ-026 Reset asserted mid-transaction abandons the transaction; the arbiter does not replay it.
REQ-027 After wb_rst_n rises, the first grant occurs no earlier than the second rising edge of wb_clk.

Configuration
REQ-028 Macro SDRAM_ARB_STARVE_EN:
  - Defined: the starvation counter and REQ-022 are compiled in.
  - Undefined: strict m0-over-m1 priority, no counter logic, and STARVE_MAX is ignored.

Structure
REQ-029 Package sdram_arb_pkg holds:
  - the state encoding (IDLE = 2'b00, G0 = 2'b01, G1 = 2'b10; identical to the gnt encoding);
  - the CTI constants CTI_CLASSIC = 3'b000 and CTI_INCR = 3'b010.
REQ-030 One sub-module, sdram_arb_starve, holds the starvation counter; it is instantiated only under SDRAM_ARB_STARVE_EN.

Verification
REQ-031 Only m1 requests (read, adr 24'h001000); slave acks 3 cycles later with 32'hDEADBEEF; m1 drops cyc.
  - Required: gnt = 10 one cycle after the request.
  - Required: m1_ack pulses one cycle and m_dat_o = DEADBEEF in that cycle.
  - Required: IDLE one cycle after cyc falls.
REQ-032 m0 and m1 raise requests on the same edge.
  - Required: gnt = 01 and s_adr = m0_adr.
  - Required: m1_ack = 0 throughout.
  - Required: after m0 releases, one IDLE cycle, then gnt = 10.
REQ-033 m0 issues a cti=010 burst with two acks while m1 is requesting.
  - Required: gnt stays 01 across both acks.
  - Required: s_cti = 010 for the whole burst.
  - Required: m1 is granted only after m0_cyc falls.
REQ-034 wb_rst_n pulled low mid-G1 while s_ack is high.
  - Required: gnt = 00, s_cyc = 0 and m1_ack = 0 in the same cycle.
  - Required: re-arbitration occurs after reset release.
REQ-035 With SDRAM_ARB_STARVE_EN and STARVE_MAX=4, m0 and m1 both request continuously.
  - Required: grant sequence m0, m0, m0, m0, m1, m0...
  - Required without the macro: m1 is never granted.
